// File: rtl/eth_arp_tx.sv
// eth_arp_tx: one-shot broadcast ARP request frame generator on a GMII transmit path, with CRC-32 FCS and inter-frame gap
//   phy1_125M_clk, reset_n (sync, active-low)
//   start, gratuitous, target_ip[31:0] : frame request, target IP latched when the request is taken
//   busy, done, frame_count[15:0]     : frame in progress, end-of-IFG pulse, completed-frame count
//   tx_en, tx_data[7:0]               : GMII transmit
module eth_arp_tx #(
  parameter logic [47:0] SRC_MAC = 48'h00301ba0a48e,
  parameter logic [31:0] SRC_IP = 32'h0a00150a,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES = 12
) (
  input  logic        phy1_125M_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        gratuitous,
  input  logic [31:0] target_ip,
  output logic        busy,
  output logic        done,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [15:0] frame_count
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, FCS, IFG} state_t;
  state_t state;
  logic [7:0] cnt, lim, byte_c;
  logic [31:0] crc;
  logic [479:0] sr;
  logic last;
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hedb88320 : r >> 1;
    return r;
  endfunction
  always_comb begin
    lim = state == PRE ? 8'(PREAMBLE_LEN - 1) : state == DATA ? 8'd59 : state == FCS ? 8'd3 :
          state == IFG ? 8'(IFG_CYCLES - 1) : 8'd0;
    last = cnt == lim;
    byte_c = state == PRE ? 8'h55 : state == SFD ? 8'hd5 : state == DATA ? sr[479:472] :
             state == FCS ? ~crc[{cnt[1:0], 3'b000} +: 8] : 8'h00;
  end
  // the whole 60-byte payload is captured at acceptance and shifted out MSB byte first
  always_ff @(posedge phy1_125M_clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      crc <= 32'hffffffff;
      sr <= '0;
      tx_en <= 1'b0;
      tx_data <= 8'h00;
      busy <= 1'b0;
      done <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      state <= state == IDLE ? (start ? PRE : IDLE) : !last ? state : state == IFG ? IDLE : state_t'(state + 3'd1);
      cnt <= (state == IDLE || last) ? 8'd0 : cnt + 8'd1;
      crc <= state == DATA ? crc_next(crc, sr[479:472]) : state == FCS ? crc : 32'hffffffff;
      if (state == IDLE && start)
        sr <= {48'hffffffffffff, SRC_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
               SRC_MAC, SRC_IP, 48'h0, gratuitous ? SRC_IP : target_ip, 144'h0};
      else if (state == DATA)
        sr <= sr << 8;
      tx_en <= state != IDLE && state != IFG;
      tx_data <= byte_c;
      busy <= state != IDLE;
      done <= state == IFG && last;
      frame_count <= frame_count + 16'(state == IFG && last);
    end
  end
endmodule
